// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// Optional macro ALU_ARB_ERR_EN adds RESP0_ERR/RESP1_ERR flags for reserved select codes.
module alu_arbiter #(
  parameter int DATA_W    = 8,
  parameter int ADD_LAT   = 2,
  parameter int LOGIC_LAT = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ0_VALID,
  input  logic [2:0]        REQ0_OP,
  input  logic [DATA_W-1:0] REQ0_A,
  input  logic [DATA_W-1:0] REQ0_B,
  output logic              REQ0_READY,
  output logic              RESP0_VALID,
  output logic [DATA_W-1:0] RESP0_DATA,
  input  logic              REQ1_VALID,
  input  logic [2:0]        REQ1_OP,
  input  logic [DATA_W-1:0] REQ1_A,
  input  logic [DATA_W-1:0] REQ1_B,
  output logic              REQ1_READY,
  output logic              RESP1_VALID,
  output logic [DATA_W-1:0] RESP1_DATA,
  output logic [DATA_W-1:0] ALU_DATA1,
  output logic [DATA_W-1:0] ALU_DATA2,
  output logic [2:0]        ALU_SELECT,
  input  logic [DATA_W-1:0] ALU_RESULT
`ifdef ALU_ARB_ERR_EN
  ,
  output logic              RESP0_ERR,
  output logic              RESP1_ERR
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic              rr_q, rr_d;        // requester granted last
  logic              owner_q, owner_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] d1_q, d1_d, d2_q, d2_d;
  logic [2:0]        sel_q, sel_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              grant0, grant1;
`ifdef ALU_ARB_ERR_EN
  logic              err_q, err_d;
`endif

  function automatic logic is_reserved(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic [7:0] op_latency(input logic [2:0] op);
    if (is_reserved(op))   return 8'd1;
    else if (op == 3'b001) return 8'(ADD_LAT);
    else                   return 8'(LOGIC_LAT);
  endfunction

  always_comb begin
    grant0 = REQ0_VALID & (~REQ1_VALID | rr_q);
    grant1 = REQ1_VALID & (~REQ0_VALID | ~rr_q);
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    d1_d     = d1_q;
    d2_d     = d2_q;
    sel_d    = sel_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifdef ALU_ARB_ERR_EN
    err_d    = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant0) begin
          d1_d    = REQ0_A;
          d2_d    = REQ0_B;
          sel_d   = REQ0_OP;
          owner_d = 1'b0;
          rr_d    = 1'b0;
          cnt_d   = op_latency(REQ0_OP);
          state_d = EXEC;
        end else if (grant1) begin
          d1_d    = REQ1_A;
          d2_d    = REQ1_B;
          sel_d   = REQ1_OP;
          owner_d = 1'b1;
          rr_d    = 1'b1;
          cnt_d   = op_latency(REQ1_OP);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q <= 8'd1) begin
          // Reserved selects never expose whatever the ALU drives for them.
          if (owner_q == 1'b0)
            rdata0_d = is_reserved(sel_q) ? '0 : ALU_RESULT;
          else
            rdata1_d = is_reserved(sel_q) ? '0 : ALU_RESULT;
`ifdef ALU_ARB_ERR_EN
          err_d   = is_reserved(sel_q);
`endif
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      rr_q     <= 1'b1;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      d1_q     <= '0;
      d2_q     <= '0;
      sel_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef ALU_ARB_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      d1_q     <= d1_d;
      d2_q     <= d2_d;
      sel_q    <= sel_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef ALU_ARB_ERR_EN
      err_q    <= err_d;
`endif
    end
  end

  assign REQ0_READY  = (state_q == IDLE) & grant0;
  assign REQ1_READY  = (state_q == IDLE) & grant1;
  assign RESP0_VALID = (state_q == RESP) & (owner_q == 1'b0);
  assign RESP1_VALID = (state_q == RESP) & (owner_q == 1'b1);
  assign RESP0_DATA  = rdata0_q;
  assign RESP1_DATA  = rdata1_q;
  assign ALU_DATA1   = d1_q;
  assign ALU_DATA2   = d2_q;
  assign ALU_SELECT  = sel_q;
`ifdef ALU_ARB_ERR_EN
  assign RESP0_ERR   = RESP0_VALID & err_q;
  assign RESP1_ERR   = RESP1_VALID & err_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 8-bit ALU model.
module tb_alu_arbiter;

  logic       CLK, RESET;
  logic       REQ0_VALID, REQ1_VALID;
  logic [2:0] REQ0_OP, REQ1_OP;
  logic [7:0] REQ0_A, REQ0_B, REQ1_A, REQ1_B;
  logic       REQ0_READY, REQ1_READY, RESP0_VALID, RESP1_VALID;
  logic [7:0] RESP0_DATA, RESP1_DATA;
  logic [7:0] ALU_DATA1, ALU_DATA2, ALU_RESULT;
  logic [2:0] ALU_SELECT;
`ifdef ALU_ARB_ERR_EN
  logic       RESP0_ERR, RESP1_ERR;
`endif

  int n_vec = 0;
  int n_err = 0;

  alu_arbiter #(.DATA_W(8), .ADD_LAT(2), .LOGIC_LAT(1)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0_VALID(REQ0_VALID), .REQ0_OP(REQ0_OP), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B),
    .REQ0_READY(REQ0_READY), .RESP0_VALID(RESP0_VALID), .RESP0_DATA(RESP0_DATA),
    .REQ1_VALID(REQ1_VALID), .REQ1_OP(REQ1_OP), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B),
    .REQ1_READY(REQ1_READY), .RESP1_VALID(RESP1_VALID), .RESP1_DATA(RESP1_DATA),
    .ALU_DATA1(ALU_DATA1), .ALU_DATA2(ALU_DATA2), .ALU_SELECT(ALU_SELECT),
    .ALU_RESULT(ALU_RESULT)
`ifdef ALU_ARB_ERR_EN
    , .RESP0_ERR(RESP0_ERR), .RESP1_ERR(RESP1_ERR)
`endif
  );

  // ALU model: 000 forward DATA2, 001 add, 010 and, 011 or, others drive junk.
  always_comb begin
    case (ALU_SELECT)
      3'b000:  ALU_RESULT = ALU_DATA2;
      3'b001:  ALU_RESULT = ALU_DATA1 + ALU_DATA2;
      3'b010:  ALU_RESULT = ALU_DATA1 & ALU_DATA2;
      3'b011:  ALU_RESULT = ALU_DATA1 | ALU_DATA2;
      default: ALU_RESULT = 8'hA5;
    endcase
  end

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic req, input logic v, input logic [2:0] op,
                       input logic [7:0] a, input logic [7:0] b);
    if (req == 1'b0) begin
      REQ0_VALID = v; REQ0_OP = op; REQ0_A = a; REQ0_B = b;
    end else begin
      REQ1_VALID = v; REQ1_OP = op; REQ1_A = a; REQ1_B = b;
    end
  endtask

  // Waits (bounded) for a response on requester `req` and checks its data.
  task automatic wait_resp(input logic req, input logic [7:0] exp, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if ((req == 1'b0) ? RESP0_VALID : RESP1_VALID) begin
        seen = 1'b1;
        chk({name, "_data"}, (req == 1'b0) ? RESP0_DATA : RESP1_DATA, exp);
      end else begin
        step();
      end
    end
    chk({name, "_seen"}, seen, 1'b1);
  endtask

  typedef struct {
    logic       req;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    int         lat;
    logic       err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic       got, hold_ok, rdy_ok, saw0, got1;
    logic [7:0] d1;
    int         k;

    vecs[0] = '{1'b0, 3'b001, 8'h03, 8'h05, 8'h08, 2, 1'b0};
    vecs[1] = '{1'b1, 3'b000, 8'hAA, 8'h55, 8'h55, 1, 1'b0};
    vecs[2] = '{1'b0, 3'b111, 8'h09, 8'h09, 8'h00, 1, 1'b1};
    vecs[3] = '{1'b0, 3'b001, 8'hFF, 8'h02, 8'h01, 2, 1'b0};
    vecs[4] = '{1'b1, 3'b010, 8'hF0, 8'h3C, 8'h30, 1, 1'b0};
    vecs[5] = '{1'b0, 3'b011, 8'h0F, 8'h30, 8'h3F, 1, 1'b0};
    vecs[6] = '{1'b1, 3'b101, 8'h01, 8'h02, 8'h00, 1, 1'b1};
    vecs[7] = '{1'b1, 3'b001, 8'h80, 8'h80, 8'h00, 2, 1'b0};

    RESET = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 3'b000, 8'h00, 8'h00);
    step();
    step();
    RESET = 1'b0;
    #1;
    chk("rst_ready", {REQ0_READY, REQ1_READY}, 2'b00);
    chk("rst_resp_valid", {RESP0_VALID, RESP1_VALID}, 2'b00);
    chk("rst_resp_data", {RESP0_DATA, RESP1_DATA}, 16'h0000);
    chk("rst_alu", {ALU_DATA1, ALU_DATA2, 5'b0, ALU_SELECT}, 32'h0);

    for (int v = 0; v < 8; v++) begin
      drive(vecs[v].req, 1'b1, vecs[v].op, vecs[v].a, vecs[v].b);
      #1;
      got = (vecs[v].req == 1'b0) ? REQ0_READY : REQ1_READY;
      chk($sformatf("v%0d_ready", v), got, 1'b1);
      step();
      // Both requesters hammer VALID with junk while the op is in flight.
      drive(1'b0, 1'b1, 3'b011, 8'hEE, 8'h11);
      drive(1'b1, 1'b1, 3'b010, 8'hDD, 8'h22);
      #1;
      hold_ok = 1'b1;
      rdy_ok  = 1'b1;
      k = 0;
      for (int c = 1; c <= 10 && k == 0; c++) begin
        if (ALU_DATA1 !== vecs[v].a || ALU_DATA2 !== vecs[v].b || ALU_SELECT !== vecs[v].op)
          hold_ok = 1'b0;
        if (REQ0_READY || REQ1_READY) rdy_ok = 1'b0;
        if (RESP0_VALID || RESP1_VALID) k = c;
        else step();
      end
      chk($sformatf("v%0d_alu_hold", v), hold_ok, 1'b1);
      chk($sformatf("v%0d_ready_busy", v), rdy_ok, 1'b1);
      chk($sformatf("v%0d_latency", v), k, vecs[v].lat + 1);
      chk($sformatf("v%0d_resp_valid", v), {RESP1_VALID, RESP0_VALID},
          (vecs[v].req == 1'b0) ? 2'b01 : 2'b10);
      chk($sformatf("v%0d_data", v), (vecs[v].req == 1'b0) ? RESP0_DATA : RESP1_DATA,
          vecs[v].res);
`ifdef ALU_ARB_ERR_EN
      chk($sformatf("v%0d_err", v), {RESP1_ERR, RESP0_ERR},
          vecs[v].err ? ((vecs[v].req == 1'b0) ? 2'b01 : 2'b10) : 2'b00);
`endif
      step();
      drive(1'b0, 1'b0, 3'b000, 8'h00, 8'h00);
      drive(1'b1, 1'b0, 3'b000, 8'h00, 8'h00);
      #1;
      chk($sformatf("v%0d_one_shot", v), {RESP0_VALID, RESP1_VALID}, 2'b00);
    end

    // Round-robin with both requesters contending, starting from reset.
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    drive(1'b0, 1'b1, 3'b010, 8'h0F, 8'h3C);
    drive(1'b1, 1'b1, 3'b011, 8'h0F, 8'h30);
    #1;
    chk("rr1_grant", {REQ0_READY, REQ1_READY}, 2'b10);
    step();
    REQ0_VALID = 1'b0;
    wait_resp(1'b0, 8'h0C, "rr1");
    chk("rr1_other_quiet", RESP1_VALID, 1'b0);
    step();
    REQ0_VALID = 1'b1;
    #1;
    chk("rr2_grant", {REQ0_READY, REQ1_READY}, 2'b01);
    step();
    REQ1_VALID = 1'b0;
    wait_resp(1'b1, 8'h3F, "rr2");
    step();
    REQ1_VALID = 1'b1;
    #1;
    chk("rr3_grant", {REQ0_READY, REQ1_READY}, 2'b10);
    step();
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    wait_resp(1'b0, 8'h0C, "rr3");
    step();

    // Reset in the first EXEC cycle aborts the add.
    drive(1'b0, 1'b1, 3'b001, 8'h01, 8'h02);
    #1;
    chk("abort_accept", REQ0_READY, 1'b1);
    step();
    REQ0_VALID = 1'b0;
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    #1;
    chk("abort_alu_zero", {ALU_DATA1, ALU_DATA2, 5'b0, ALU_SELECT}, 32'h0);
    drive(1'b1, 1'b1, 3'b001, 8'h04, 8'h04);
    #1;
    chk("abort_next_ready", REQ1_READY, 1'b1);
    step();
    REQ1_VALID = 1'b0;
    saw0 = 1'b0;
    got1 = 1'b0;
    d1   = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (RESP0_VALID) saw0 = 1'b1;
      if (RESP1_VALID) begin
        got1 = 1'b1;
        d1   = RESP1_DATA;
      end
      step();
    end
    chk("abort_no_resp0", saw0, 1'b0);
    chk("abort_resp1_seen", got1, 1'b1);
    chk("abort_resp1_data", d1, 8'h08);
    chk("abort_resp0_data", RESP0_DATA, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
